// File: rtl/word_serializer.sv
// Parallel-to-serial shifter: takes one word per valid/ready handshake and
// streams it out one bit per enabled clock, with frame-start/frame-end markers.
module word_serializer #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    // Handshake: a word transfers on a rising edge where load_valid && load_ready.
    // load_ready never depends on load_valid; upstream holds din/load_valid until then.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_last;
    logic             w_out_bit;

    assign w_last    = (r_cnt == LAST);
    assign w_shifted = LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);
    assign w_out_bit = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        load_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_shreg_nxt = din;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // The next word is taken during the last bit so words stream gap-free.
                load_ready = w_last && shift_en;
                if (shift_en) begin
                    w_shreg_nxt = w_shifted;
                    w_cnt_nxt   = r_cnt + 1'b1;
                    if (w_last) begin
                        w_cnt_nxt = '0;
                        if (load_valid) begin
                            w_shreg_nxt = din;
                            w_state_nxt = S_SHIFT;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // busy doubles as the visible FSM state (1 = SHIFT).
    assign busy        = (r_state == S_SHIFT);
    assign sout        = busy && w_out_bit;
    assign sout_valid  = busy && shift_en;
    assign frame_start = sout_valid && (r_cnt == '0);
    assign frame_end   = sout_valid && w_last;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: MSB-first and LSB-first instances on shared inputs,
// both checked every cycle against a queue-of-expected-bits reference model.
module tb_word_serializer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic         shift_en;
    logic [W-1:0] din;

    logic lr_m, so_m, sv_m, fs_m, fe_m, b_m;
    logic lr_l, so_l, sv_l, fs_l, fe_l, b_l;

    int n_cmp     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int bits_seen = 0;
    int t_start   = 0;
    int t_end     = 0;
    bit rand_stall = 1'b0;

    // Each entry is {last, first, bit} for one expected serial bit.
    logic [2:0] exp_q[$];
    logic [2:0] exp_lq[$];

    word_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut (
        .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(lr_m), .shift_en(shift_en), .sout(so_m), .sout_valid(sv_m),
        .frame_start(fs_m), .frame_end(fe_m), .busy(b_m)
    );

    word_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(lr_l), .shift_en(shift_en), .sout(so_l), .sout_valid(sv_l),
        .frame_start(fs_l), .frame_end(fe_l), .busy(b_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_stall) begin
            #1;
            shift_en = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_lane(input string nm, input int sz, input logic [2:0] fr,
                              input logic b, input logic sv, input logic so,
                              input logic fs, input logic fe, input logic lr);
        logic be, sve;
        be  = (sz != 0);
        sve = be && shift_en;
        check({nm, ".busy"},        32'(b),  32'(be));
        check({nm, ".sout_valid"},  32'(sv), 32'(sve));
        check({nm, ".sout"},        32'(so), 32'(be && fr[0]));
        check({nm, ".frame_start"}, 32'(fs), 32'(sve && fr[1]));
        check({nm, ".frame_end"},   32'(fe), 32'(sve && fr[2]));
        check({nm, ".load_ready"},  32'(lr), 32'(!be || (sz == 1 && shift_en)));
    endtask

    function automatic void push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            exp_q.push_back({i == W - 1, i == 0, w[W-1-i]});
            exp_lq.push_back({i == W - 1, i == 0, w[i]});
        end
    endfunction

    always @(negedge clk) begin
        int sz;
        logic acc;
        if (!reset) begin
            exp_q.delete();
            exp_lq.delete();
            check_lane("rst_msb", 0, 3'b000, b_m, sv_m, so_m, fs_m, fe_m, lr_m);
            check_lane("rst_lsb", 0, 3'b000, b_l, sv_l, so_l, fs_l, fe_l, lr_l);
        end else begin
            sz = exp_q.size();
            check_lane("msb", sz, (sz != 0) ? exp_q[0] : 3'b000,
                       b_m, sv_m, so_m, fs_m, fe_m, lr_m);
            check_lane("lsb", exp_lq.size(), (exp_lq.size() != 0) ? exp_lq[0] : 3'b000,
                       b_l, sv_l, so_l, fs_l, fe_l, lr_l);
            acc = load_valid && (sz == 0 || (sz == 1 && shift_en));
            if (sz != 0 && shift_en) begin
                void'(exp_q.pop_front());
                void'(exp_lq.pop_front());
            end
            if (acc) push_word(din);
            if (sv_m) bits_seen++;
            if (fs_m) t_start = cyc;
            if (fe_m) t_end = cyc;
        end
    end

    task automatic send_word(input logic [W-1:0] w);
        bit ok;
        ok = 1'b0;
        din = w;
        load_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (lr_m) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bits(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (bits_seen >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("bits_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) check({tag, ".idle_timeout"}, 32'd0, 32'd1);
        check({tag, ".idle_busy"}, 32'(b_m), 32'd0);
    endtask

    initial begin
        int gap;
        reset      = 1'b0;
        load_valid = 1'b1;
        din        = $urandom;
        shift_en   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        load_valid = 1'b0;
        reset      = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        send_word(32'hAFAFAFAF);
        load_valid = 1'b0;
        wait_idle("single");
        check("single_span", 32'(t_end - t_start + 1), 32'd32);

        send_word(32'hFFFFFFFF);
        send_word(32'h00000001);
        load_valid = 1'b0;
        wait_idle("b2b");

        bits_seen = 0;
        send_word(32'h12345678);
        load_valid = 1'b0;
        wait_bits(10);
        #1 shift_en = 1'b0;
        repeat (5) @(posedge clk);
        #1 shift_en = 1'b1;
        wait_idle("stall");
        check("stall_span", 32'(t_end - t_start + 1), 32'd37);

        bits_seen = 0;
        send_word(32'hFFFFFFFF);
        load_valid = 1'b0;
        wait_bits(16);
        #3 reset = 1'b0;
        #1;
        check_lane("arst_msb", 0, 3'b000, b_m, sv_m, so_m, fs_m, fe_m, lr_m);
        check_lane("arst_lsb", 0, 3'b000, b_l, sv_l, so_l, fs_l, fe_l, lr_l);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_word(32'h80000000);
        load_valid = 1'b0;
        wait_idle("after_rst");

        send_word(32'h00000001);
        load_valid = 1'b0;
        wait_idle("lsb_one");

        rand_stall = 1'b1;
        for (int k = 0; k < 40; k++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                load_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    din = $urandom;
                    @(posedge clk);
                    #1;
                end
            end
            send_word($urandom);
        end
        load_valid = 1'b0;
        rand_stall = 1'b0;
        @(posedge clk);
        #2 shift_en = 1'b1;
        wait_idle("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
